// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// -----------------------------------------------------------------------------
// Round-robin arbiter that shares one UART transmitter between several byte
// stream requesters. A requester that wins arbitration keeps the transmitter
// for a whole message (until its byte flagged 'last'), or until the burst
// limit is reached. Each byte is forwarded as a single-cycle THR write.
// Pacing follows the transmitter's THR-empty flag, so the block works the same
// whether or not the UART TX FIFO is enabled.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   enable_i       allows new grants; a grant already held is unaffected
//   req_valid_i    per-requester byte available
//   req_data_i     per-requester byte, requester i in bits [8*i +: 8]
//   req_last_i     per-requester "final byte of message" flag
//   req_ready_o    per-requester accept, one-hot or zero
//   thr_empty_i    THR empty (FIFO empty in FIFO mode) from the UART LSR
//   thr_write_o    single-cycle THR write strobe
//   thr_data_o     byte written with the strobe, held until the next strobe
//   grant_valid_o  a requester currently owns the transmitter
//   grant_id_o     index of the owner, keeps its last value when idle
//   busy_o         arbiter is not idle
// -----------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int NumReq      = 4,
    parameter int MaxBurst    = 0,
    parameter int GuardCycles = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [NumReq-1:0]         req_valid_i,
    input  logic [NumReq*8-1:0]       req_data_i,
    input  logic [NumReq-1:0]         req_last_i,
    output logic [NumReq-1:0]         req_ready_o,
    input  logic                      thr_empty_i,
    output logic                      thr_write_o,
    output logic [7:0]                thr_data_o,
    output logic                      grant_valid_o,
    output logic [$clog2(NumReq)-1:0] grant_id_o,
    output logic                      busy_o
);

    localparam int IdW    = $clog2(NumReq);
    localparam int BurstW = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WRITE,
        GUARD
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [IdW-1:0]    rr_q;
    logic [BurstW-1:0] burst_q;
    logic [2:0]        guard_q;
    logic              last_q;

    logic [7:0]        data_arr [NumReq];
    logic              pick_found;
    logic [IdW-1:0]    pick_id;
    logic [IdW-1:0]    cand;
    logic              owner_valid;
    logic              burst_hit;
    logic              grant_start;
    logic              accept;
    logic              release_grant;

    // Split the flat data bus into one byte per requester so the owner's byte
    // can be picked with a plain array index.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            data_arr[i] = req_data_i[i*8 +: 8];
        end
    end

    // Round-robin search: scan from the pointer upward with wrap-around and
    // take the first requester that has a byte waiting. The pointer only moves
    // on release, which is what bounds each requester to one grant per round.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = IdW'((int'(rr_q) + i) % NumReq);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign owner_valid = req_valid_i[grant_id_o];

    // The burst counter is compared for equality, so it never needs to wrap.
    // With no burst limit the comparison is disabled entirely.
    assign burst_hit = (MaxBurst != 0) && (burst_q == BurstW'(MaxBurst));

    // Next-state logic and the handshake towards the requesters. Ready is a
    // function of state and thr_empty_i only, never of req_valid_i, so there
    // is no combinational valid-to-ready path.
    always_comb begin
        state_d       = state_q;
        grant_start   = 1'b0;
        accept        = 1'b0;
        release_grant = 1'b0;
        req_ready_o   = '0;
        case (state_q)
            IDLE: begin
                if (enable_i && pick_found) begin
                    grant_start = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                req_ready_o[grant_id_o] = thr_empty_i;
                if (owner_valid && thr_empty_i) begin
                    accept  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = GUARD;
            end
            GUARD: begin
                if (guard_q == 3'd0 && thr_empty_i) begin
                    if (last_q || burst_hit) begin
                        release_grant = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant ownership and round-robin pointer. The pointer is moved past the
    // owner at release time so the next search starts with its neighbour.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_valid_o <= 1'b0;
            grant_id_o    <= '0;
            rr_q          <= '0;
        end else if (grant_start) begin
            grant_valid_o <= 1'b1;
            grant_id_o    <= pick_id;
        end else if (release_grant) begin
            grant_valid_o <= 1'b0;
            rr_q          <= (grant_id_o == IdW'(NumReq - 1)) ? '0 : grant_id_o + IdW'(1);
        end
    end

    // Byte capture and burst accounting. The byte and its 'last' flag are
    // latched on acceptance so the requester is free to present its next byte
    // while this one is still being written and guarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thr_data_o <= 8'h00;
            last_q     <= 1'b0;
            burst_q    <= '0;
        end else if (grant_start) begin
            burst_q <= '0;
        end else if (accept) begin
            thr_data_o <= data_arr[grant_id_o];
            last_q     <= req_last_i[grant_id_o];
            if (MaxBurst != 0) begin
                burst_q <= burst_q + BurstW'(1);
            end
        end
    end

    // Guard countdown. The LSR takes a few cycles to drop THR-empty after a
    // write; thr_empty_i is ignored until this counter has run out so a stale
    // "empty" cannot release the next byte too early.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            guard_q <= 3'd0;
        end else if (state_q == WRITE) begin
            guard_q <= 3'(GuardCycles);
        end else if (state_q == GUARD && guard_q != 3'd0) begin
            guard_q <= guard_q - 3'd1;
        end
    end

    assign thr_write_o = (state_q == WRITE);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// -----------------------------------------------------------------------------
// Self-checking bench for uart_tx_arb. Two instances share all inputs: one with
// unlimited bursts and one with a burst limit of 2; the bench follows whichever
// instance 'sel_b' selects. Requesters are modelled as byte queues; the
// expected THR writes (owner id and byte) are queued when stimulus is driven
// and compared as the selected instance emits its write strobes.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int NumReq      = 4;
    localparam int GuardCycles = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic        thr_empty = 1'b1;

    logic [3:0]  ready_a, ready_b, ready_s;
    logic        write_a, write_b, write_s;
    logic [7:0]  data_a, data_b, data_s;
    logic        gv_a, gv_b, gv_s;
    logic [1:0]  gid_a, gid_b, gid_s;
    logic        busy_a, busy_b, busy_s;
    bit          sel_b = 1'b0;

    logic [8:0]  q0[$], q1[$], q2[$], q3[$];
    logic [9:0]  exp_q[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          pass_count = 0;
    int          check_count = 0;
    logic [3:0]  hs;

    uart_tx_arb #(.NumReq(NumReq), .MaxBurst(0), .GuardCycles(GuardCycles)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(ready_a), .thr_empty_i(thr_empty), .thr_write_o(write_a),
        .thr_data_o(data_a), .grant_valid_o(gv_a), .grant_id_o(gid_a), .busy_o(busy_a)
    );

    uart_tx_arb #(.NumReq(NumReq), .MaxBurst(2), .GuardCycles(GuardCycles)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(ready_b), .thr_empty_i(thr_empty), .thr_write_o(write_b),
        .thr_data_o(data_b), .grant_valid_o(gv_b), .grant_id_o(gid_b), .busy_o(busy_b)
    );

    assign ready_s = sel_b ? ready_b : ready_a;
    assign write_s = sel_b ? write_b : write_a;
    assign data_s  = sel_b ? data_b  : data_a;
    assign gv_s    = sel_b ? gv_b    : gv_a;
    assign gid_s   = sel_b ? gid_b   : gid_a;
    assign busy_s  = sel_b ? busy_b  : busy_a;

    // Free-running clock.
    initial begin
        forever #5 clk = ~clk;
    end

    // Cycle counter, bumped on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got === want) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Present the head of each requester queue on the valid/data/last inputs.
    task automatic refresh_drive();
        logic [8:0] e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        if (q0.size() != 0) begin e = q0[0]; req_valid[0] = 1'b1; req_data[7:0]   = e[7:0]; req_last[0] = e[8]; end
        if (q1.size() != 0) begin e = q1[0]; req_valid[1] = 1'b1; req_data[15:8]  = e[7:0]; req_last[1] = e[8]; end
        if (q2.size() != 0) begin e = q2[0]; req_valid[2] = 1'b1; req_data[23:16] = e[7:0]; req_last[2] = e[8]; end
        if (q3.size() != 0) begin e = q3[0]; req_valid[3] = 1'b1; req_data[31:24] = e[7:0]; req_last[3] = e[8]; end
    endtask

    // Queue one byte on a requester and drive it immediately if it is the head.
    task automatic applyStimulus(input int id, input logic [7:0] d, input logic last);
        case (id)
            0: q0.push_back({last, d});
            1: q1.push_back({last, d});
            2: q2.push_back({last, d});
            default: q3.push_back({last, d});
        endcase
        refresh_drive();
    endtask

    task automatic push_expected(input int id, input logic [7:0] d);
        exp_q.push_back({2'(id), d});
    endtask

    task automatic pop_req(input int id);
        case (id)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    // Requester model: a byte leaves its queue when valid and ready were both
    // high across a rising edge; inputs change 1 time unit after that edge.
    initial begin
        forever begin
            @(negedge clk);
            hs = req_valid & ready_s;
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int i = 0; i < NumReq; i++) begin
                    if (hs[i]) pop_req(i);
                end
            end
            refresh_drive();
        end
    end

    // Scoreboard: every write strobe must match the oldest expected entry.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (write_s) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(write_s), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_data", 32'(data_s), 32'(e[7:0]));
                    checkOutput("wr_id", 32'(gid_s), 32'(e[9:8]));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait for all expected writes, bounded; a leftover count is a failure.
    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        exp_q.delete();
        wr_cyc.delete();
        refresh_drive();
        enable    = 1'b1;
        thr_empty = 1'b1;
        @(negedge clk);
        checkOutput("rst_grant_valid", 32'(gv_s), 32'd0);
        checkOutput("rst_busy", 32'(busy_s), 32'd0);
        checkOutput("rst_write", 32'(write_s), 32'd0);
        checkOutput("rst_ready", 32'(ready_s), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", check_count);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bad;
        int t0;

        // Single requester, three-byte message, write spacing and release.
        sel_b = 1'b0;
        apply_reset();
        push_expected(0, 8'h41); push_expected(0, 8'h42); push_expected(0, 8'h43);
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b1);
        wait_drain("t1_drain", 60);
        checkOutput("t1_write_count", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            checkOutput("t1_gap_1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
            checkOutput("t1_gap_2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd5);
        end
        step(6);
        @(negedge clk);
        checkOutput("t1_grant_released", 32'(gv_s), 32'd0);
        checkOutput("t1_idle", 32'(busy_s), 32'd0);
        step(1);
        // Pointer now sits at 1, so requester 1 wins over requester 0.
        push_expected(1, 8'h51); push_expected(0, 8'h50);
        applyStimulus(0, 8'h50, 1'b1);
        applyStimulus(1, 8'h51, 1'b1);
        wait_drain("t1_rr_drain", 60);

        // Requester 0 keeps re-requesting; requester 2 must alternate with it.
        apply_reset();
        push_expected(0, 8'h10); push_expected(2, 8'h20);
        push_expected(0, 8'h11); push_expected(2, 8'h21);
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(2, 8'h20, 1'b1);
        applyStimulus(2, 8'h21, 1'b1);
        wait_drain("t2_drain", 100);

        // Backpressure: THR full for 20 cycles while in SEND.
        apply_reset();
        thr_empty = 1'b0;
        push_expected(3, 8'h5A);
        applyStimulus(3, 8'h5A, 1'b1);
        step(2);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready_s != 4'b0000 || write_s) bad++;
        end
        checkOutput("t3_hold_quiet", 32'(bad), 32'd0);
        checkOutput("t3_grant_valid", 32'(gv_s), 32'd1);
        checkOutput("t3_grant_id", 32'(gid_s), 32'd3);
        @(posedge clk);
        #2;
        thr_empty = 1'b1;
        t0 = cyc;
        @(negedge clk);
        checkOutput("t3_ready", 32'(ready_s), 32'h8);
        wait_drain("t3_drain", 20);
        checkOutput("t3_write_count", 32'(wr_cyc.size()), 32'd1);
        if (wr_cyc.size() == 1) begin
            checkOutput("t3_write_cycle", 32'(wr_cyc[0]), 32'(t0 + 1));
        end

        // Burst limit of 2: requester 1's long message interleaves with 3.
        sel_b = 1'b1;
        apply_reset();
        push_expected(1, 8'hB0); push_expected(1, 8'hB1);
        push_expected(3, 8'hC0);
        push_expected(1, 8'hB2); push_expected(1, 8'hB3);
        push_expected(3, 8'hC1);
        push_expected(1, 8'hB4);
        applyStimulus(1, 8'hB0, 1'b0);
        applyStimulus(1, 8'hB1, 1'b0);
        applyStimulus(1, 8'hB2, 1'b0);
        applyStimulus(1, 8'hB3, 1'b0);
        applyStimulus(1, 8'hB4, 1'b1);
        applyStimulus(3, 8'hC0, 1'b1);
        applyStimulus(3, 8'hC1, 1'b1);
        wait_drain("t4_drain", 200);
        step(6);
        sel_b = 1'b0;

        // enable dropped mid-message: message finishes, then no new grant.
        apply_reset();
        push_expected(2, 8'hD0); push_expected(2, 8'hD1); push_expected(2, 8'hD2);
        applyStimulus(2, 8'hD0, 1'b0);
        applyStimulus(2, 8'hD1, 1'b0);
        applyStimulus(2, 8'hD2, 1'b1);
        t0 = 0;
        while (exp_q.size() > 2 && t0 < 50) begin
            @(posedge clk);
            t0++;
        end
        #2;
        enable = 1'b0;
        applyStimulus(0, 8'hE0, 1'b1);
        applyStimulus(1, 8'hE1, 1'b1);
        wait_drain("t5_msg_done", 60);
        step(5);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (gv_s || busy_s || ready_s != 4'b0000) bad++;
        end
        checkOutput("t5_held_idle", 32'(bad), 32'd0);
        step(1);
        push_expected(0, 8'hE0); push_expected(1, 8'hE1);
        enable = 1'b1;
        wait_drain("t5_resume", 60);

        // Reset asserted during GUARD.
        apply_reset();
        push_expected(2, 8'hF0);
        applyStimulus(2, 8'hF0, 1'b1);
        wait_drain("t6_first", 40);
        checkOutput("t6_in_guard_busy", 32'(busy_s), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1, 8'h61, 1'b1);
        applyStimulus(3, 8'h63, 1'b1);
        #1;
        checkOutput("t6_rst_grant_valid", 32'(gv_s), 32'd0);
        checkOutput("t6_rst_grant_id", 32'(gid_s), 32'd0);
        checkOutput("t6_rst_data", 32'(data_s), 32'd0);
        checkOutput("t6_rst_write", 32'(write_s), 32'd0);
        checkOutput("t6_rst_ready", 32'(ready_s), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy_s), 32'd0);
        step(2);
        push_expected(1, 8'h61); push_expected(3, 8'h63);
        rst_n = 1'b1;
        wait_drain("t6_after_reset", 60);

        step(4);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the UART transmitter between `NumReq` byte-stream requesters (e.g. firmware console, debug/trace unit, boot-status reporter). It accepts bytes on per-requester valid/ready channels and holds the grant for a whole message, up to `req_last_i` or the burst limit. Each byte is delivered to the transmitter as a one-cycle THR write strobe with data. Pacing comes from the transmitter's THR-empty status, so the block works with the TX FIFO enabled or disabled.

## Interface
- `NumReq`, default 4: number of requesters, 2..8.
- `MaxBurst`, default 0: maximum bytes per grant; 0 means unlimited (grant held until `last`).
- `GuardCycles`, default 2: cycles after a THR write during which `thr_empty_i` is ignored; covers the LSR update latency. Range 1..7.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `enable_i`  in  1: permits new grants. Has no effect on a grant already held.
- `req_valid_i`  in  NumReq: byte available, one bit per requester.
- `req_data_i`  in  NumReq×8: byte per requester.
- `req_last_i`  in  NumReq: the byte is the final byte of the message.
- `req_ready_o`  out  NumReq: byte accepted this cycle when valid&ready; one-hot or zero.
- `thr_empty_i`  in  1: LSR THR-empty (FIFO empty in FIFO mode).
- `thr_write_o`  out  1: one-cycle THR write strobe.
- `thr_data_o`  out  8: byte written with the strobe; held until the next strobe.
- `grant_valid_o`  out  1: a requester currently owns the transmitter.
- `grant_id_o`  out  $clog2(NumReq): index of the owner; holds its last value when there is no grant.
- `busy_o`  out  1: state is not IDLE.

## Operation
- States: IDLE, SEND, WRITE, GUARD. Reset → IDLE.
- All outputs reset to 0. Round-robin pointer `rr_q` resets to 0. Burst counter resets to 0.
- **IDLE:**
  - If `enable_i` and any `req_valid_i` is set, select the first valid index scanning `rr_q`, `rr_q`+1, … modulo NumReq.
  - Register it in `grant_id_o`, set `grant_valid_o`, clear the burst counter, and go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - `req_ready_o[grant_id]` = `thr_empty_i`. This is combinational from state and input; no other bit is ever set.
  - On valid&ready: latch the data into `thr_data_o`, latch `last`, increment the burst counter, and go to WRITE.
  - If the owner's valid is low, wait in SEND indefinitely with the grant held.
- **WRITE:** `thr_write_o`=1 for exactly this cycle; load the guard counter with GuardCycles; go to GUARD.
- **GUARD:**
  - Decrement the guard counter each cycle.
  - Once it reaches 0, wait for `thr_empty_i`=1. Then:
    - If the latched `last` is set, or `MaxBurst`≠0 and the burst count equals `MaxBurst`: release the grant, set `rr_q` = grant_id+1 (wrapping), and go to IDLE.
    - Otherwise go to SEND.
- `enable_i` low does not abort a message; it only blocks the next IDLE→SEND.
- A burst-limit release mid-message lets other requesters interleave. The message resumes on a later grant of the same requester.
- Burst counter width is $clog2(MaxBurst+1), minimum 1 bit. It never wraps, because release occurs at equality.
- Reset asserted mid-operation returns everything to reset values immediately. A byte in flight in WRITE is dropped unless its strobe has already been emitted.

## Timing
- Requester in IDLE with `thr_empty_i`=1, `req_valid_i` high at cycle 0:
  - cycle 1: SEND, `req_ready_o` high, transfer.
  - cycle 2: `thr_write_o`.
  - cycles 3..2+GuardCycles: GUARD countdown.
  - next byte accepted no earlier than cycle 3+GuardCycles+1.
- Arbitration takes one cycle. No combinational path from `req_valid_i` to `req_ready_o`.
- Grant change: at least one IDLE cycle between consecutive grants.
- The pointer advances only on release, so a requester that stays valid is served at most once per round.

## Test plan
- Single requester 0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), `thr_empty_i` held 1, GuardCycles=2:
  - three `thr_write_o` pulses, 5 cycles apart, data in order.
  - `grant_valid_o` falls after the third; `rr_q`=1.
- Requesters 0 and 2 both valid with 1-byte messages; requester 0 continuously re-requests:
  - grant order 0, 2, 0, 2.
  - never two consecutive grants to 0 while 2 is valid.
- Backpressure: hold `thr_empty_i`=0 for 20 cycles during SEND:
  - `req_ready_o` stays 0, no strobe.
  - transfer occurs in the first cycle `thr_empty_i` returns 1.
- MaxBurst=2, requester 1 sends a 5-byte message while requester 3 is valid:
  - bytes 1,1 → 3's message → 1,1 → 3 → 1.
  - `grant_id_o` follows this sequence.
- `enable_i` dropped mid-message on requester 2:
  - the message completes through `last`.
  - afterwards IDLE persists with no grant while other valids are high, until `enable_i` returns.
- Assert `rst_ni`=0 while in GUARD:
  - all outputs 0 immediately; state IDLE.
  - after release, the first grant goes to the lowest valid index ≥0.
